// File: rtl/spi_slave_sr.sv
// Parametrised SPI slave shift register, all four CPOL/CPHA modes, clk-domain oversampled.
// Optional short-frame error strobe built when SPI_SR_FRAME_ERR_EN is defined.
module spi_slave_sr #(
    parameter int WIDTH = 8,
    parameter bit CPOL  = 1'b0,
    parameter bit CPHA  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sclk,
    input  logic             spi_ss_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_sclk_s1, r_sclk_s2, r_sclk_prev;
    logic r_ss_s1, r_ss_s2, r_ss_prev;
    logic r_mosi_s1, r_mosi_s2;
    logic r_sync_vld;
    logic r_ss_armed;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-2:0] r_rx_sr;
    logic [WIDTH-1:0] r_tx_sr;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_hold;

    logic w_sclk_chg, w_lead, w_trail;
    logic w_sample, w_shift;
    logic w_ss_fall, w_ss_rise;
    logic w_start, w_stop, w_act, w_word;
    logic [WIDTH-1:0] w_rx_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_s1   <= CPOL;
            r_sclk_s2   <= CPOL;
            r_sclk_prev <= CPOL;
            r_ss_s1     <= 1'b1;
            r_ss_s2     <= 1'b1;
            r_ss_prev   <= 1'b1;
            r_mosi_s1   <= 1'b0;
            r_mosi_s2   <= 1'b0;
            r_sync_vld  <= 1'b0;
            r_ss_armed  <= 1'b0;
        end else begin
            r_sclk_s1   <= spi_sclk;
            r_sclk_s2   <= r_sclk_s1;
            r_sclk_prev <= r_sclk_s2;
            r_ss_s1     <= spi_ss_n;
            r_ss_s2     <= r_ss_s1;
            r_ss_prev   <= r_ss_s2;
            r_mosi_s1   <= spi_mosi;
            r_mosi_s2   <= r_mosi_s1;
            r_sync_vld  <= 1'b1;
            // A fall only counts once ss_n has really been sampled high since reset
            r_ss_armed  <= r_ss_armed | (r_sync_vld & r_ss_s1);
        end
    end

    assign w_sclk_chg = r_sclk_s2 ^ r_sclk_prev;
    assign w_lead     = w_sclk_chg & (r_sclk_s2 != CPOL);
    assign w_trail    = w_sclk_chg & (r_sclk_s2 == CPOL);
    assign w_sample   = CPHA ? w_trail : w_lead;
    assign w_shift    = CPHA ? w_lead : w_trail;

    assign w_ss_fall  = r_ss_prev & ~r_ss_s2 & r_ss_armed;
    assign w_ss_rise  = ~r_ss_prev & r_ss_s2;

    assign w_start    = (r_state == S_IDLE) & w_ss_fall;
    assign w_stop     = (r_state == S_ACTIVE) & w_ss_rise;
    assign w_act      = (r_state == S_ACTIVE) & ~w_ss_rise;
    assign w_word     = w_act & w_sample & (r_cnt == CW'(WIDTH - 1));
    assign w_rx_nxt   = {r_rx_sr, r_mosi_s2};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_stop)  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_rx_sr    <= '0;
            r_tx_sr    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_start) begin
                r_cnt   <= '0;
                r_tx_sr <= tx_data;
                r_hold  <= CPHA;
            end else if (w_act) begin
                if (w_sample) begin
                    r_rx_sr <= w_rx_nxt[WIDTH-2:0];
                    if (w_word) begin
                        r_cnt      <= '0;
                        r_rx_data  <= w_rx_nxt;
                        r_rx_valid <= 1'b1;
                        r_tx_sr    <= tx_data;
                        // Reload already shows the next MSB; skip the next shift edge
                        r_hold     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else if (w_shift) begin
                    if (r_hold) begin
                        r_hold <= 1'b0;
                    end else begin
                        r_tx_sr <= {r_tx_sr[WIDTH-2:0], 1'b0};
                    end
                end
            end
        end
    end

`ifdef SPI_SR_FRAME_ERR_EN
    logic r_frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_stop & (r_cnt != '0);
        end
    end

    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    assign busy        = (r_state == S_ACTIVE);
    assign spi_miso_oe = busy;
    assign spi_miso    = busy & r_tx_sr[WIDTH-1];
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_sr.sv
// Directed bench for spi_slave_sr: 8-bit mode 0 instance plus 48-bit modes 1, 2, 3.
// Short-frame error expectation follows SPI_SR_FRAME_ERR_EN.
module tb_spi_slave_sr;

    localparam logic [3:0] CPOLS = 4'b1100;
    localparam logic [3:0] CPHAS = 4'b1010;
`ifdef SPI_SR_FRAME_ERR_EN
    localparam int FE = 1;
`else
    localparam int FE = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] sclk_p = 4'b1100;
    logic [3:0] ss_p = 4'b1111;
    logic [3:0] mosi_p = 4'b0000;
    logic [3:0] miso_w, oe_w, busy_w, rxv_w, ferr_w;
    logic [7:0]  tx0 = 8'h00;
    logic [47:0] tx1 = 48'h0, tx2 = 48'h0, tx3 = 48'h0;
    logic [7:0]  rxd0;
    logic [47:0] rxd1, rxd2, rxd3;

    int nerr = 0;
    int nchk = 0;
    int vcnt[4] = '{0, 0, 0, 0};
    int ecnt[4] = '{0, 0, 0, 0};
    logic [7:0] log0[16];

    always #5 clk = ~clk;

    spi_slave_sr #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_d0 (
        .clk(clk), .reset(reset), .spi_sclk(sclk_p[0]), .spi_ss_n(ss_p[0]),
        .spi_mosi(mosi_p[0]), .spi_miso(miso_w[0]), .spi_miso_oe(oe_w[0]),
        .tx_data(tx0), .rx_data(rxd0), .rx_valid(rxv_w[0]), .busy(busy_w[0]),
        .frame_err(ferr_w[0]));

    spi_slave_sr #(.WIDTH(48), .CPOL(1'b0), .CPHA(1'b1)) u_d1 (
        .clk(clk), .reset(reset), .spi_sclk(sclk_p[1]), .spi_ss_n(ss_p[1]),
        .spi_mosi(mosi_p[1]), .spi_miso(miso_w[1]), .spi_miso_oe(oe_w[1]),
        .tx_data(tx1), .rx_data(rxd1), .rx_valid(rxv_w[1]), .busy(busy_w[1]),
        .frame_err(ferr_w[1]));

    spi_slave_sr #(.WIDTH(48), .CPOL(1'b1), .CPHA(1'b0)) u_d2 (
        .clk(clk), .reset(reset), .spi_sclk(sclk_p[2]), .spi_ss_n(ss_p[2]),
        .spi_mosi(mosi_p[2]), .spi_miso(miso_w[2]), .spi_miso_oe(oe_w[2]),
        .tx_data(tx2), .rx_data(rxd2), .rx_valid(rxv_w[2]), .busy(busy_w[2]),
        .frame_err(ferr_w[2]));

    spi_slave_sr #(.WIDTH(48), .CPOL(1'b1), .CPHA(1'b1)) u_d3 (
        .clk(clk), .reset(reset), .spi_sclk(sclk_p[3]), .spi_ss_n(ss_p[3]),
        .spi_mosi(mosi_p[3]), .spi_miso(miso_w[3]), .spi_miso_oe(oe_w[3]),
        .tx_data(tx3), .rx_data(rxd3), .rx_valid(rxv_w[3]), .busy(busy_w[3]),
        .frame_err(ferr_w[3]));

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rxv_w[k]) vcnt[k] <= vcnt[k] + 1;
            if (ferr_w[k]) ecnt[k] <= ecnt[k] + 1;
        end
        if (rxv_w[0]) log0[vcnt[0] & 15] <= rxd0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_tx(input int k, input logic [47:0] v);
        case (k)
            0: tx0 = v[7:0];
            1: tx1 = v;
            2: tx2 = v;
            default: tx3 = v;
        endcase
    endtask

    task automatic clk_bit(input int k, input logic b, input bit raise_ss,
                           input bit chg, input logic [47:0] txn, output logic mb);
        if (!CPHAS[k]) begin
            mosi_p[k] = b;
            wclk(4);
            mb = miso_w[k];
            sclk_p[k] = ~CPOLS[k];
            if (raise_ss) ss_p[k] = 1'b1;
            if (chg) set_tx(k, txn);
            wclk(4);
            sclk_p[k] = CPOLS[k];
            wclk(4);
        end else begin
            sclk_p[k] = ~CPOLS[k];
            mosi_p[k] = b;
            wclk(4);
            mb = miso_w[k];
            sclk_p[k] = CPOLS[k];
            if (raise_ss) ss_p[k] = 1'b1;
            if (chg) set_tx(k, txn);
            wclk(4);
        end
    endtask

    task automatic xfer(input int k, input logic [63:0] data, input int nbits,
                        input bit coincide, input int chg_at, input logic [47:0] txn,
                        output logic [63:0] cap, output logic act);
        logic mb;
        ss_p[k] = 1'b0;
        wclk(4);
        act = busy_w[k] & oe_w[k];
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            clk_bit(k, data[nbits-1-i], coincide && (i == nbits - 1),
                    i == chg_at, txn, mb);
            cap = {cap[62:0], mb};
        end
        ss_p[k] = 1'b1;
        wclk(6);
    endtask

    logic [63:0] cap;
    logic act, mb;
    int v0, e0, vk;

    initial begin
        wclk(4);
        reset = 1'b0;
        wclk(1);
        chk("rst_rx_data", 64'(rxd0), 64'h0);
        chk("rst_rx_valid", 64'(rxv_w[0]), 64'h0);
        chk("rst_busy", 64'(busy_w), 64'h0);
        chk("rst_miso", 64'(miso_w), 64'h0);
        chk("rst_miso_oe", 64'(oe_w), 64'h0);
        chk("rst_frame_err", 64'(ferr_w), 64'h0);
        wclk(4);

        // Mode 0 single byte
        tx0 = 8'h3C;
        v0 = vcnt[0];
        xfer(0, 64'hA5, 8, 1'b0, -1, 48'h0, cap, act);
        chk("m0_rx_data", 64'(rxd0), 64'hA5);
        chk("m0_rx_valid_cnt", 64'(vcnt[0] - v0), 64'd1);
        chk("m0_miso", cap & 64'hFF, 64'h3C);
        chk("m0_busy_oe", 64'(act), 64'h1);
        chk("m0_idle_after", 64'(busy_w[0]), 64'h0);

        // 48-bit frames in modes 1, 2, 3
        tx1 = 48'hA5A5_0F0F_C3C3;
        tx2 = 48'h8000_0000_0001;
        tx3 = 48'h1234_5678_9ABC;
        for (int k = 1; k < 4; k++) begin
            vk = vcnt[k];
            xfer(k, 64'h1FF_FFFF_FFFF, 48, 1'b0, -1, 48'h0, cap, act);
            chk($sformatf("m%0d_rx_data", k),
                64'(k == 1 ? rxd1 : (k == 2 ? rxd2 : rxd3)), 64'h01FF_FFFF_FFFF);
            chk($sformatf("m%0d_rx_valid_cnt", k), 64'(vcnt[k] - vk), 64'd1);
            chk($sformatf("m%0d_miso", k), cap & 64'hFFFF_FFFF_FFFF,
                64'(k == 1 ? 48'hA5A5_0F0F_C3C3 :
                   (k == 2 ? 48'h8000_0000_0001 : 48'h1234_5678_9ABC)));
        end

        // Back-to-back bytes, tx word swapped at the first word boundary
        tx0 = 8'hC3;
        v0 = vcnt[0];
        xfer(0, 64'h1234, 16, 1'b0, 7, 48'h56, cap, act);
        chk("b2b_rx_valid_cnt", 64'(vcnt[0] - v0), 64'd2);
        chk("b2b_word0", 64'(log0[v0 & 15]), 64'h12);
        chk("b2b_word1", 64'(log0[(v0 + 1) & 15]), 64'h34);
        chk("b2b_rx_data", 64'(rxd0), 64'h34);
        chk("b2b_miso", cap & 64'hFFFF, 64'hC356);

        // Short frame of 5 bits
        v0 = vcnt[0];
        e0 = ecnt[0];
        xfer(0, 64'h1F, 5, 1'b0, -1, 48'h0, cap, act);
        chk("short_rx_valid_cnt", 64'(vcnt[0] - v0), 64'd0);
        chk("short_rx_data", 64'(rxd0), 64'h34);
        chk("short_frame_err", 64'(ecnt[0] - e0), 64'(FE));

        // Reset mid-frame with ss_n held low through release
        v0 = vcnt[0];
        ss_p[0] = 1'b0;
        wclk(4);
        for (int i = 0; i < 4; i++) clk_bit(0, 1'b1, 1'b0, 1'b0, 48'h0, mb);
        reset = 1'b1;
        wclk(3);
        reset = 1'b0;
        wclk(1);
        chk("mid_rst_rx_data", 64'(rxd0), 64'h0);
        chk("mid_rst_busy", 64'(busy_w[0]), 64'h0);
        chk("mid_rst_oe", 64'(oe_w[0]), 64'h0);
        chk("mid_rst_miso", 64'(miso_w[0]), 64'h0);
        for (int i = 0; i < 8; i++) clk_bit(0, 1'b1, 1'b0, 1'b0, 48'h0, mb);
        chk("held_low_busy", 64'(busy_w[0]), 64'h0);
        chk("held_low_rx_valid_cnt", 64'(vcnt[0] - v0), 64'd0);
        ss_p[0] = 1'b1;
        wclk(6);
        tx0 = 8'h81;
        xfer(0, 64'h5A, 8, 1'b0, -1, 48'h0, cap, act);
        chk("post_rst_rx_data", 64'(rxd0), 64'h5A);
        chk("post_rst_miso", cap & 64'hFF, 64'h81);
        chk("post_rst_rx_valid_cnt", 64'(vcnt[0] - v0), 64'd1);

        // ss_n rise coincident with the eighth sample edge
        v0 = vcnt[0];
        e0 = ecnt[0];
        xfer(0, 64'hFF, 8, 1'b1, -1, 48'h0, cap, act);
        chk("coinc_rx_valid_cnt", 64'(vcnt[0] - v0), 64'd0);
        chk("coinc_rx_data", 64'(rxd0), 64'h5A);
        chk("coinc_frame_err", 64'(ecnt[0] - e0), 64'(FE));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
